// File: rtl/product_accumulator_if.sv
// Valid/ready bus between the 2x2 multiplier and the product accumulator:
// product channel in, frame-sum channel out.
interface product_accumulator_if #(
  parameter int ACC_W = 8
);
  logic [3:0]       p_in;
  logic             p_valid;
  logic             p_ready;
  logic [ACC_W-1:0] sum_out;
  logic             sum_ovf;
  logic             sum_valid;
  logic             sum_ready;

  modport master (
    output p_in, p_valid, sum_ready,
    input  p_ready, sum_out, sum_ovf, sum_valid
  );

  modport slave (
    input  p_in, p_valid, sum_ready,
    output p_ready, sum_out, sum_ovf, sum_valid
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums frames of N 4-bit multiplier products into a saturating accumulator and
// hands each frame sum downstream over a valid/ready handshake.
module product_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  localparam int SUM_W = ACC_W + 1;
  localparam logic [7:0] N_CNT = 8'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Returns {overflow, value}; addends are non-negative so only the carry
  // out of the ACC_W-bit range can signal overflow.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [3:0]       b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + SUM_W'(b);
    if (s[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [7:0]       cnt_q;
  logic             ovf_q;
  logic             sum_valid_q;
  logic [ACC_W-1:0] sum_out_q;
  logic             sum_ovf_q;

  logic [ACC_W:0]   sat_d;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_d;
  logic [7:0]       cnt_d;

  always_comb begin
    sat_d = sat_add(acc_q, bus.p_in);
    acc_d = sat_d[ACC_W-1:0];
    ovf_d = ovf_q | sat_d[ACC_W];
    cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_out_q   <= '0;
      sum_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.p_valid) begin
            acc_q <= ACC_W'(bus.p_in);
            cnt_q <= 8'd1;
            if (N_CNT == 8'd1) begin
              state_q     <= DONE;
              sum_valid_q <= 1'b1;
              sum_out_q   <= ACC_W'(bus.p_in);
              sum_ovf_q   <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (bus.p_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (cnt_d == N_CNT) begin
              state_q     <= DONE;
              sum_valid_q <= 1'b1;
              sum_out_q   <= acc_d;
              sum_ovf_q   <= ovf_d;
            end
          end
        end
        DONE: begin
          // Output registers are cleared on handoff so sum_out reads 0 when idle.
          if (bus.sum_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
            sum_out_q   <= '0;
            sum_ovf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.p_ready   = !rst && (state_q != DONE);
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum_out   = sum_out_q;
  assign bus.sum_ovf   = sum_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives five accumulator configurations from one shared stimulus stream and
// checks every output, every cycle, against a frame-sum model.
module tb_product_accumulator;

  localparam int NI = 5;
  localparam int NS [NI] = '{4, 4, 2, 3, 1};
  localparam int WS [NI] = '{8, 4, 8, 8, 8};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] p_in;
  logic       p_valid;
  logic       sum_ready;

  logic [NI-1:0]       pr_v;
  logic [NI-1:0]       sv_v;
  logic [NI-1:0]       ov_v;
  logic [NI-1:0][15:0] so_v;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    product_accumulator_if #(.ACC_W(WS[g])) bus ();
    assign bus.p_in      = p_in;
    assign bus.p_valid   = p_valid;
    assign bus.sum_ready = sum_ready;
    product_accumulator #(.N(NS[g]), .ACC_W(WS[g])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign pr_v[g] = bus.p_ready;
    assign sv_v[g] = bus.sum_valid;
    assign ov_v[g] = bus.sum_ovf;
    assign so_v[g] = 16'(bus.sum_out);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: true (unbounded) frame sum and product count; saturation is
  // applied only when the sum is presented.
  int m_sum [NI];
  int m_cnt [NI];
  bit m_done[NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_sum[i] <= 0; m_cnt[i] <= 0; m_done[i] <= 1'b0;
      end else if (m_done[i]) begin
        if (sum_ready) begin
          m_sum[i] <= 0; m_cnt[i] <= 0; m_done[i] <= 1'b0;
        end
      end else if (p_valid) begin
        m_sum[i] <= m_sum[i] + int'(p_in);
        m_cnt[i] <= m_cnt[i] + 1;
        if (m_cnt[i] + 1 == NS[i]) m_done[i] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int mx;
      int eo;
      mx = (1 << WS[i]) - 1;
      eo = m_done[i] ? ((m_sum[i] > mx) ? mx : m_sum[i]) : 0;
      chk($sformatf("p_ready[%0d]", i),   32'(pr_v[i]), 32'(!rst && !m_done[i]));
      chk($sformatf("sum_valid[%0d]", i), 32'(sv_v[i]), 32'(m_done[i]));
      chk($sformatf("sum_out[%0d]", i),   32'(so_v[i]), 32'(eo));
      chk($sformatf("sum_ovf[%0d]", i),   32'(ov_v[i]), 32'(m_done[i] && (m_sum[i] > mx)));
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] p, input logic sr);
    @(negedge clk);
    #1;
    rst = r; p_valid = v; p_in = p; sum_ready = sr;
  endtask

  initial begin
    rst = 1'b1; p_valid = 1'b1; p_in = 4'd9; sum_ready = 1'b0;

    // Reset held two cycles with a product offered
    @(negedge clk); #1;
    chk("rst_p_ready", 32'(pr_v), 32'd0);
    chk("rst_sum_valid", 32'(sv_v), 32'd0);
    step(1, 1, 9, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("post_rst_p_ready", 32'(pr_v), 32'h1f);
    chk("post_rst_sum_valid", 32'(sv_v), 32'd0);
    chk("post_rst_sum_out", 32'(so_v[0]), 32'd0);

    // Basic frame 1,2,3,6 on instance 0 (N=4, ACC_W=8)
    step(1, 0, 0, 1);
    step(0, 1, 1, 1); step(0, 1, 2, 1); step(0, 1, 3, 1); step(0, 1, 6, 1);
    step(0, 0, 0, 1);
    chk("basic_sum_valid", 32'(sv_v[0]), 32'd1);
    chk("basic_sum_out", 32'(so_v[0]), 32'd12);
    chk("basic_sum_ovf", 32'(ov_v[0]), 32'd0);
    chk("basic_p_ready_done", 32'(pr_v[0]), 32'd0);
    step(0, 0, 0, 1);
    chk("basic_p_ready_after", 32'(pr_v[0]), 32'd1);

    // Saturation on instance 1 (N=4, ACC_W=4)
    step(1, 0, 0, 0);
    step(0, 1, 9, 0); step(0, 1, 9, 0); step(0, 1, 1, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("sat_sum_out", 32'(so_v[1]), 32'd15);
    chk("sat_sum_ovf", 32'(ov_v[1]), 32'd1);
    step(0, 0, 0, 1);
    step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    chk("sat_next_sum_out", 32'(so_v[1]), 32'd4);
    chk("sat_next_sum_ovf", 32'(ov_v[1]), 32'd0);

    // Backpressure on instance 2 (N=2) with a product held
    step(1, 0, 0, 0);
    step(0, 1, 4, 0); step(0, 1, 4, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 3, 0);
      chk("bp_sum_out", 32'(so_v[2]), 32'd8);
      chk("bp_p_ready", 32'(pr_v[2]), 32'd0);
    end
    step(0, 1, 3, 1);
    step(0, 1, 3, 0);
    step(0, 1, 6, 0);
    step(0, 0, 0, 0);
    chk("bp_held_sum_out", 32'(so_v[2]), 32'd9);

    // Gaps on instance 3 (N=3): 2,_,_,5,_,7
    step(1, 0, 0, 0);
    step(0, 1, 2, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 5, 0); step(0, 0, 0, 0); step(0, 1, 7, 0);
    step(0, 0, 0, 0);
    chk("gap_sum_valid", 32'(sv_v[3]), 32'd1);
    chk("gap_sum_out", 32'(so_v[3]), 32'd14);

    // N=1 on instance 4
    step(1, 0, 0, 0);
    step(0, 1, 9, 0);
    step(0, 0, 0, 0);
    chk("n1_sum_valid", 32'(sv_v[4]), 32'd1);
    chk("n1_sum_out", 32'(so_v[4]), 32'd9);

    // Mid-frame reset on instance 0
    step(1, 0, 0, 0);
    step(0, 1, 1, 1); step(0, 1, 2, 1); step(0, 1, 4, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("midrst_sum_valid", 32'(sv_v[0]), 32'd0);
    step(0, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    chk("midrst_next_sum_out", 32'(so_v[0]), 32'd4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
